// File: rtl/ysyx_l1i_cache.sv
// rtl/ysyx_l1i_cache.sv - direct-mapped L1 instruction cache with burst/single-beat refill
module ysyx_l1i_cache #(
    parameter int              XLEN        = 32,
    parameter int              SET_LEN     = 2,
    parameter int              LINE_LEN    = 1,
    parameter int              BURST_EN    = 1,
    parameter logic [XLEN-1:0] BURST_BASE  = 32'ha000_0000,
    parameter logic [XLEN-1:0] BURST_LIMIT = 32'hc000_0000,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [XLEN-1:0]  req_pc,
    output logic             rsp_valid_o,
    output logic [31:0]      inst_o,
    output logic             ready_o,
    input  logic             fence_i,
    output logic [XLEN-1:0]  araddr_o,
    output logic             arvalid_o,
    input  logic             arready,
    output logic [7:0]       arlen_o,
    output logic [1:0]       arburst_o,
    input  logic [31:0]      rdata,
    input  logic             rvalid,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    output logic             err_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int SETS   = 1 << SET_LEN;
    localparam int WORDS  = 1 << LINE_LEN;
    localparam int IDX_LO = LINE_LEN + 2;
    localparam int TAG_LO = SET_LEN + LINE_LEN + 2;
    localparam int TAG_W  = XLEN - TAG_LO;
    localparam logic [LINE_LEN-1:0] LAST_BEAT = LINE_LEN'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_FILL
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_arr  [SETS];
    logic [31:0]         data_arr [SETS][WORDS];

    logic [XLEN-1:0]     base_q;
    logic                burst_q;
    logic [LINE_LEN-1:0] beat_q;
    logic                err_pending_q;
    logic                flush_pending_q;
    logic [CNT_W-1:0]    hit_cnt_q;
    logic [CNT_W-1:0]    miss_cnt_q;

    logic [LINE_LEN-1:0] req_off;
    logic [SET_LEN-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [XLEN-1:0]     line_base;
    logic [SET_LEN-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                lookup_hit;
    logic                idle_hit;
    logic                idle_miss;
    logic                burst_sel;
    logic                last_beat;
    logic                unused_pc_bits;

    assign req_off        = req_pc[LINE_LEN+1:2];
    assign req_idx        = req_pc[TAG_LO-1:IDX_LO];
    assign req_tag        = req_pc[XLEN-1:TAG_LO];
    assign line_base      = {req_pc[XLEN-1:IDX_LO], {IDX_LO{1'b0}}};
    assign fill_idx       = base_q[TAG_LO-1:IDX_LO];
    assign fill_tag       = base_q[XLEN-1:TAG_LO];
    assign unused_pc_bits = ^req_pc[1:0];

    assign lookup_hit = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign idle_hit   = (state_q == S_IDLE) && req_valid && lookup_hit;
    assign idle_miss  = (state_q == S_IDLE) && req_valid && !lookup_hit;
    assign burst_sel  = (BURST_EN != 0) && (line_base >= BURST_BASE) && (line_base < BURST_LIMIT);
    assign last_beat  = (beat_q == LAST_BEAT);

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    // State register, valid bits, refill bookkeeping and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            valid_q         <= '0;
            base_q          <= '0;
            burst_q         <= 1'b0;
            beat_q          <= '0;
            err_pending_q   <= 1'b0;
            flush_pending_q <= 1'b0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (fence_i) begin
                        valid_q <= '0;
                    end
                    if (idle_hit && (hit_cnt_q != '1)) begin
                        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    end
                    if (idle_miss) begin
                        base_q          <= line_base;
                        burst_q         <= burst_sel;
                        beat_q          <= '0;
                        err_pending_q   <= 1'b0;
                        flush_pending_q <= 1'b0;
                        if (miss_cnt_q != '1) begin
                            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_AR: begin
                    if (fence_i) begin
                        flush_pending_q <= 1'b1;
                    end
                end
                S_R: begin
                    if (fence_i) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (rvalid) begin
                        beat_q <= beat_q + LINE_LEN'(1);
                        // A burst whose rlast does not land on the final word is treated as a bad refill
                        if ((rresp != 2'b00) || (burst_q && (rlast != last_beat))) begin
                            err_pending_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (flush_pending_q || fence_i) begin
                        valid_q <= '0;
                    end else if (err_pending_q) begin
                        // The data words were overwritten, so the old line must not survive
                        valid_q[fill_idx] <= 1'b0;
                    end else begin
                        valid_q[fill_idx] <= 1'b1;
                    end
                    err_pending_q   <= 1'b0;
                    flush_pending_q <= 1'b0;
                    beat_q          <= '0;
                end
                default: ;
            endcase
        end
    end

    // Line storage: data written per returned beat, tag written at the end of refill
    always_ff @(posedge clk) begin
        if ((state_q == S_R) && rvalid) begin
            data_arr[fill_idx][beat_q] <= rdata;
        end
        if (state_q == S_FILL) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

    // Next state and bus/response outputs
    always_comb begin
        state_d     = state_q;
        ready_o     = 1'b0;
        rsp_valid_o = 1'b0;
        inst_o      = '0;
        arvalid_o   = 1'b0;
        araddr_o    = '0;
        arlen_o     = '0;
        arburst_o   = 2'b00;
        err_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (req_valid) begin
                    if (lookup_hit) begin
                        rsp_valid_o = 1'b1;
                        inst_o      = data_arr[req_idx][req_off];
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                arvalid_o = 1'b1;
                araddr_o  = base_q + XLEN'({beat_q, 2'b00});
                arlen_o   = burst_q ? 8'(WORDS - 1) : 8'd0;
                arburst_o = burst_q ? 2'b01 : 2'b00;
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    if (burst_q) begin
                        if (rlast) begin
                            state_d = S_FILL;
                        end
                    end else if (last_beat) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_FILL: begin
                err_o   = err_pending_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_l1i_cache.sv
// tb/tb_ysyx_l1i_cache.sv - randomized scoreboard bench for ysyx_l1i_cache
module tb_ysyx_l1i_cache;

    localparam int SET_LEN    = 2;
    localparam int LINE_LEN   = 1;
    localparam int CNT_W      = 4;
    localparam int SETS       = 1 << SET_LEN;
    localparam int WORDS      = 1 << LINE_LEN;
    localparam int LINE_BYTES = 4 * WORDS;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [31:0]      req_pc;
    logic             rsp_valid_o;
    logic [31:0]      inst_o;
    logic             ready_o;
    logic             fence_i;
    logic             fence_drv;
    logic             fence_bus;
    logic [31:0]      araddr_o;
    logic             arvalid_o;
    logic             arready;
    logic [7:0]       arlen_o;
    logic [1:0]       arburst_o;
    logic [31:0]      rdata;
    logic             rvalid;
    logic [1:0]       rresp;
    logic             rlast;
    logic             err_o;
    logic [CNT_W-1:0] hit_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;

    assign fence_i = fence_drv | fence_bus;

    ysyx_l1i_cache #(
        .XLEN(32), .SET_LEN(SET_LEN), .LINE_LEN(LINE_LEN), .BURST_EN(1),
        .BURST_BASE(32'ha000_0000), .BURST_LIMIT(32'hc000_0000), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
        .rsp_valid_o(rsp_valid_o), .inst_o(inst_o), .ready_o(ready_o), .fence_i(fence_i),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready(arready), .arlen_o(arlen_o),
        .arburst_o(arburst_o), .rdata(rdata), .rvalid(rvalid), .rresp(rresp), .rlast(rlast),
        .err_o(err_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ar_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] inst_q[$];
    ar_t         ar_q[$];
    int          rsp_seen = 0;
    int          ar_seen  = 0;
    int          err_seen = 0;
    bit          err_plan[int];
    bit          fence_plan[int];

    bit          m_valid[SETS];
    logic [31:0] m_tag[SETS];
    int          m_hit = 0;
    int          m_miss = 0;
    int          m_err = 0;
    int          ar_issued = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
        ar_t e;
        e.addr  = a;
        e.len   = len;
        e.burst = b;
        ar_q.push_back(e);
        ar_issued++;
    endtask

    task automatic clear_model_valid();
        for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    endtask

    // One line refill as the reference model sees it
    task automatic refill_expect(input logic [31:0] pc, input bit err, input bit fref);
        logic [31:0] base;
        bit          burst;
        int          idx;
        base  = pc - (pc % LINE_BYTES);
        burst = (base >= 32'ha000_0000) && (base < 32'hc000_0000);
        idx   = int'((pc / LINE_BYTES) % SETS);
        if (m_miss < CNT_MAX) m_miss++;
        if (err)  err_plan[ar_issued]   = 1'b1;
        if (fref) fence_plan[ar_issued] = 1'b1;
        if (burst) begin
            push_ar(base, 8'(WORDS - 1), 2'b01);
        end else begin
            for (int w = 0; w < WORDS; w++) push_ar(base + 32'(4 * w), 8'd0, 2'b00);
        end
        if (err) m_err++;
        if (fref) clear_model_valid();
        if (err || fref) begin
            m_valid[idx] = 1'b0;
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc / (LINE_BYTES * SETS);
        end
    endtask

    // Issue one fetch, hold it until the response, then check counters
    task automatic fetch(input logic [31:0] pc, input bit err, input bit fref, input bit fidle);
        int idx;
        bit hit;
        int prev;
        int guard;
        idx = int'((pc / LINE_BYTES) % SETS);
        hit = m_valid[idx] && (m_tag[idx] == pc / (LINE_BYTES * SETS));
        if (!hit) begin
            refill_expect(pc, err, fref);
            if (err || fref) refill_expect(pc, 1'b0, 1'b0);
        end
        if (m_hit < CNT_MAX) m_hit++;
        inst_q.push_back(mem_word(pc & 32'hffff_fffc));
        prev      = rsp_seen;
        req_pc    = pc;
        req_valid = 1'b1;
        fence_drv = fidle && hit;
        guard     = 0;
        while (rsp_seen == prev && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        #1;
        req_valid = 1'b0;
        fence_drv = 1'b0;
        if (rsp_seen == prev) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout pc=%h no response within %0d cycles", pc, guard);
            inst_q.delete();
            ar_q.delete();
        end
        if (fidle && hit) clear_model_valid();
        chk("hit_cnt", 32'(hit_cnt_o), m_hit);
        chk("miss_cnt", 32'(miss_cnt_o), m_miss);
        chk("err_pulses", err_seen, m_err);
        chk("ar_handshakes", ar_seen, ar_issued);
    endtask

    // Monitor: compare every presented response and address handshake with the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid_o) begin
                if (inst_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected inst=%h", inst_o);
                end else begin
                    chk("inst", inst_o, inst_q.pop_front());
                end
                chk("rsp_ready", 32'(ready_o), 32'd1);
                rsp_seen++;
            end
            if (arvalid_o && arready) begin
                if (ar_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_unexpected araddr=%h", araddr_o);
                end else begin
                    ar_t e;
                    e = ar_q.pop_front();
                    chk("araddr", araddr_o, e.addr);
                    chk("arlen", 32'(arlen_o), 32'(e.len));
                    chk("arburst", 32'(arburst_o), 32'(e.burst));
                end
                ar_seen++;
            end
            if (err_o) err_seen++;
        end
    end

    // Bus responder: random arready/rvalid delays, errors and fences from the plans
    initial begin : bus
        int          n;
        int          hs;
        logic [31:0] a;
        hs        = 0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rresp     = 2'b00;
        rdata     = '0;
        fence_bus = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && arvalid_o) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                a       = araddr_o;
                n       = int'(arlen_o) + 1;
                arready = 1'b1;
                @(posedge clk);
                #1;
                arready = 1'b0;
                for (int b = 0; b < n; b++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                    rvalid    = 1'b1;
                    rdata     = mem_word(a + 32'(4 * b));
                    rresp     = (b == 0 && err_plan.exists(hs)) ? 2'b10 : 2'b00;
                    rlast     = (b == n - 1);
                    fence_bus = (b == 0 && fence_plan.exists(hs));
                    @(posedge clk);
                    #1;
                    rvalid    = 1'b0;
                    rlast     = 1'b0;
                    rresp     = 2'b00;
                    fence_bus = 1'b0;
                end
                hs++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: reset, directed scenarios, random fetches, reset during refill
    initial begin : stim
        logic [31:0] regions [7];
        logic [31:0] pc;
        int          prev;
        int          guard;
        regions[0] = 32'ha000_0000;
        regions[1] = 32'ha000_0020;
        regions[2] = 32'h3000_0000;
        regions[3] = 32'h3000_0020;
        regions[4] = 32'hbfff_ffe0;
        regions[5] = 32'hc000_0000;
        regions[6] = 32'h9fff_ffe0;
        clear_model_valid();
        for (int s = 0; s < SETS; s++) m_tag[s] = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        fence_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_arvalid", 32'(arvalid_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_hit_cnt", 32'(hit_cnt_o), 32'd0);
        chk("reset_miss_cnt", 32'(miss_cnt_o), 32'd0);
        chk("reset_inst", inst_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fetch(32'ha000_0004, 0, 0, 0);
        fetch(32'ha000_0000, 0, 0, 0);
        fetch(32'h3000_0000, 0, 0, 0);
        fetch(32'h3000_0004, 0, 0, 0);
        fetch(32'h8000_0000, 0, 0, 0);
        fetch(32'h8000_0020, 0, 0, 0);
        fetch(32'h8000_0000, 0, 0, 0);
        fetch(32'ha000_0010, 0, 1, 0);
        fetch(32'ha000_0010, 0, 0, 1);
        fetch(32'ha000_0014, 0, 0, 0);
        fetch(32'h3000_0008, 1, 0, 0);
        fetch(32'ha000_0018, 1, 0, 0);
        fetch(32'ha000_0018, 0, 0, 0);

        for (int i = 0; i < 160; i++) begin
            pc = regions[$urandom_range(0, 6)] + 32'(4 * $urandom_range(0, 7));
            fetch(pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 11) == 0) begin
                fence_drv = 1'b1;
                @(posedge clk);
                #1;
                fence_drv = 1'b0;
                clear_model_valid();
            end
        end

        // Asynchronous reset while the refill is in its data phase
        pc = 32'ha000_0040;
        push_ar(pc, 8'(WORDS - 1), 2'b01);
        prev      = ar_seen;
        req_pc    = pc;
        req_valid = 1'b1;
        guard     = 0;
        while (ar_seen == prev && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (ar_seen == prev) begin
            checks++;
            errors++;
            $display("FAIL reset_test_ar_timeout no handshake within %0d cycles", guard);
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", 32'(ready_o), 32'd1);
        chk("midreset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("midreset_hit_cnt", 32'(hit_cnt_o), 32'd0);
        chk("midreset_miss_cnt", 32'(miss_cnt_o), 32'd0);
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model_valid();
        m_hit  = 0;
        m_miss = 0;
        @(posedge clk);
        #1;
        fetch(pc, 0, 0, 0);
        fetch(pc + 32'd4, 0, 0, 0);

        repeat (4) @(posedge clk);
        chk("inst_queue_drained", inst_q.size(), 32'd0);
        chk("ar_queue_drained", ar_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
